text_console_writer: RTL

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

---
 rtl/console_pkg.sv | 26 ++
 rtl/console_addr.sv | 25 ++
 rtl/text_console_writer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared constants, control codes and FSM states for the text console writer
package console_pkg;

  localparam int COLS_DEFAULT = 160;
  localparam int ROWS_DEFAULT = 45;

  localparam logic [11:0] CLEAR_FG = 12'hFFF;
  localparam logic [11:0] CLEAR_BG = 12'h000;

  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_CR = 8'h0D;
  localparam logic [7:0] CODE_BS = 8'h08;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    PROC,
    CLEAR_LINE
  } state_t;

  // Increment a 6-bit row index, wrapping back to 0 after rows-1.
  function automatic logic [5:0] wrap_inc(input logic [5:0] value, input int rows);
    return (value == 6'(rows - 1)) ? 6'd0 : value + 6'd1;
  endfunction

endpackage

// File: rtl/console_addr.sv
// rtl/console_addr.sv - maps (screen row, scroll offset, column) to a framebuffer word address
module console_addr
  import console_pkg::*;
#(
  parameter int COLS  = COLS_DEFAULT,
  parameter int ROWS  = ROWS_DEFAULT,
  parameter int COL_W = $clog2(COLS)
) (
  input  logic [5:0]       row,
  input  logic [5:0]       v_offset,
  input  logic [COL_W-1:0] col,
  output logic [12:0]      addr
);

  logic [6:0]  sum;
  logic [6:0]  phys;
  logic [12:0] row_base;

  // Both operands are below ROWS, so a single conditional subtract wraps the sum.
  assign sum      = {1'b0, row} + {1'b0, v_offset};
  assign phys     = (sum >= 7'(ROWS)) ? sum - 7'(ROWS) : sum;
  assign row_base = 13'(COLS) * {6'd0, phys};
  assign addr     = row_base + {{(13 - COL_W){1'b0}}, col};

endmodule

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - character stream to circular text framebuffer writer with scrolling
module text_console_writer
  import console_pkg::*;
#(
  parameter int          COLS  = COLS_DEFAULT,
  parameter int          ROWS  = ROWS_DEFAULT,
  parameter logic [7:0]  SPACE = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [11:0] fg,
  input  logic [11:0] bg,
  output logic [12:0] write_addr,
  output logic [31:0] write_value,
  output logic        write_enable,
  output logic [5:0]  v_offset
);

  localparam int               COL_W    = $clog2(COLS);
  localparam logic [12:0]      LAST_ALL = 13'(COLS * ROWS - 1);
  localparam logic [12:0]      LAST_CLR = 13'(COLS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [5:0]       LAST_ROW = 6'(ROWS - 1);

  state_t           state, state_next;
  logic             run;
  logic [COL_W-1:0] col, col_next;
  logic [5:0]       row, row_next;
  logic [5:0]       voff_next;
  logic [12:0]      cnt, cnt_next;
  logic [7:0]       code_l;
  logic [11:0]      fg_l, bg_l;

  logic [5:0]       addr_row;
  logic [COL_W-1:0] addr_col;
  logic [12:0]      mapped_addr;
  logic             linear;
  logic             advance;

  console_addr #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W)
  ) u_addr (
    .row      (addr_row),
    .v_offset (v_offset),
    .col      (addr_col),
    .addr     (mapped_addr)
  );

  assign write_addr = linear ? cnt : mapped_addr;

  // run holds off the full clear for one cycle so nothing is written while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR_ALL;
      run      <= 1'b0;
      col      <= '0;
      row      <= '0;
      v_offset <= '0;
      cnt      <= '0;
      code_l   <= '0;
      fg_l     <= '0;
      bg_l     <= '0;
    end else begin
      state    <= state_next;
      run      <= 1'b1;
      col      <= col_next;
      row      <= row_next;
      v_offset <= voff_next;
      cnt      <= cnt_next;
      if (state == IDLE && char_valid) begin
        code_l <= char_data;
        fg_l   <= fg;
        bg_l   <= bg;
      end
    end
  end

  always_comb begin
    state_next   = state;
    col_next     = col;
    row_next     = row;
    voff_next    = v_offset;
    cnt_next     = cnt;
    char_ready   = 1'b0;
    write_enable = 1'b0;
    write_value  = '0;
    addr_row     = row;
    addr_col     = col;
    linear       = 1'b0;
    advance      = 1'b0;

    case (state)
      CLEAR_ALL: begin
        linear = 1'b1;
        if (run) begin
          write_enable = 1'b1;
          write_value  = {CLEAR_FG, CLEAR_BG, SPACE};
          if (cnt == LAST_ALL) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + 13'd1;
          end
        end
      end

      IDLE: begin
        char_ready = 1'b1;
        if (char_valid) state_next = PROC;
      end

      PROC: begin
        state_next = IDLE;
        case (code_l)
          CODE_CR: col_next = '0;
          CODE_LF: begin
            col_next = '0;
            advance  = 1'b1;
          end
          CODE_BS: begin
            if (col != '0) col_next = col - COL_W'(1);
          end
          default: begin
            write_enable = 1'b1;
            write_value  = {fg_l, bg_l, code_l};
            if (col == LAST_COL) begin
              col_next = '0;
              advance  = 1'b1;
            end else begin
              col_next = col + COL_W'(1);
            end
          end
        endcase
        // On the bottom row the cursor stays put and the oldest physical row is recycled instead.
        if (advance) begin
          if (row == LAST_ROW) state_next = CLEAR_LINE;
          else                 row_next   = row + 6'd1;
        end
      end

      CLEAR_LINE: begin
        write_enable = 1'b1;
        write_value  = {fg_l, bg_l, SPACE};
        addr_row     = '0;
        addr_col     = cnt[COL_W-1:0];
        if (cnt == LAST_CLR) begin
          cnt_next   = '0;
          voff_next  = wrap_inc(v_offset, ROWS);
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 13'd1;
        end
      end

      default: state_next = CLEAR_ALL;
    endcase
  end

endmodule
